// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a single-issue ALU, with per-requester response FIFOs and op locking.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0 first) otherwise.
module alu_arb #(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [4:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_ci,
  input  logic       req0_lock,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [4:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_ci,
  input  logic       req1_lock,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_out,
  output logic       rsp0_c,
  output logic       rsp0_v,
  output logic       rsp0_bpage,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_out,
  output logic       rsp1_c,
  output logic       rsp1_v,
  output logic       rsp1_bpage,
  output logic [4:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ci,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_bpage
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned D_W   = 8;
  localparam int unsigned RSP_W = D_W + 3;
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam logic [OP_W-1:0] ALU_NOP = '0;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;

  logic [1:0] valid, lock, rsp_rdy, rsp_vld, pop, elig, want, ready, accept;
  logic [RSP_W-1:0] rsp_dat [2];
  logic [RSP_W-1:0] alu_res;
  logic             tag_valid, tag_id;
  logic             prefer1;

  assign valid   = {req1_valid, req0_valid};
  assign lock    = {req1_lock, req0_lock};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign alu_res = {alu_out, alu_c, alu_v, alu_bpage};
  assign want    = valid & elig;
  assign accept  = valid & ready;

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign {rsp0_out, rsp0_c, rsp0_v, rsp0_bpage} = rsp_dat[0];
  assign {rsp1_out, rsp1_c, rsp1_v, rsp1_bpage} = rsp_dat[1];

  // Response FIFO and credit tracking; credit = in-flight op + queued responses.
  for (genvar n = 0; n < 2; n++) begin : g_rsp
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [RSP_W-1:0] mem [RSP_DEPTH];
    logic             push;
    logic [CRD_W-1:0] credit;

    assign push       = tag_valid && (tag_id == 1'(n));
    assign rsp_vld[n] = rst && (cnt != '0);
    assign pop[n]     = rsp_vld[n] && rsp_rdy[n];
    assign rsp_dat[n] = rsp_vld[n] ? mem[rd_ptr] : '0;
    assign credit     = CRD_W'(cnt) + CRD_W'(push);
    assign elig[n]    = (credit < CRD_W'(RSP_DEPTH)) ||
                        ((credit == CRD_W'(RSP_DEPTH)) && pop[n]);

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= alu_res;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)   wr_ptr <= ptr_inc(wr_ptr);
        if (pop[n]) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop[n]})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef ALU_ARB_RR_EN
  // Pointer names the preferred requester; flips whenever both contend in OPEN.
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if ((state_q == OPEN) && (&want)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign prefer1 = rr_ptr;
`else
  assign prefer1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= OPEN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OPEN: begin
        if (accept[0] && lock[0])      state_d = LOCK0;
        else if (accept[1] && lock[1]) state_d = LOCK1;
      end
      LOCK0:   if (accept[0] && !lock[0]) state_d = OPEN;
      LOCK1:   if (accept[1] && !lock[1]) state_d = OPEN;
      default: state_d = OPEN;
    endcase
  end

  // Grant: the lock owner alone may issue; otherwise the non-preferred side yields on contention.
  always_comb begin
    ready = '0;
    case (state_q)
      OPEN: begin
        ready[0] = elig[0] && !(want[1] && prefer1);
        ready[1] = elig[1] && !(want[0] && !prefer1);
      end
      LOCK0:   ready[0] = elig[0];
      LOCK1:   ready[1] = elig[1];
      default: ready = '0;
    endcase
    if (!rst) ready = '0;
  end

  always_comb begin
    alu_op = ALU_NOP;
    alu_a  = '0;
    alu_b  = '0;
    alu_ci = 1'b0;
    if (accept[0]) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_ci = req0_ci;
    end else if (accept[1]) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_ci = req1_ci;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      tag_valid <= |accept;
      tag_id    <= accept[1];
    end
  end

endmodule
